caravel_user_fir: RTL and testbench
===================================

// Module: caravel_user_fir
// PURPOSE
//  Wishbone-slave 11-tap FIR accelerator in the Caravel user area, at 0x3000_0000.
//  Firmware loads the taps and the data length, then sets ap_start.
//  Firmware then streams X in and reads Y out, one sample at a time.
//  Firmware copies each Y to mprj_io[31:16]: start mark 0xAB40, 64 samples, end mark 0xAB51, run 3 times.
// PARAMETERS
//  NUM_TAPS   11      number of coefficients / length of the sample history
//  DATA_W     32      width of coefficients, samples and accumulator
//  BASE_HI    8'h30   value of wbs_adr_i[31:24] that selects this block
// PORTS
//  wb_clk_i    in   1   system clock
//  wb_rst_i    in   1   synchronous active-high reset
//  wbs_cyc_i   in   1   Wishbone cycle
//  wbs_stb_i   in   1   Wishbone strobe
//  wbs_we_i    in   1   1 = write
//  wbs_sel_i   in   4   byte enables (applied to register writes)
//  wbs_adr_i   in   32  byte address
//  wbs_dat_i   in   32  write data
//  wbs_ack_o   out  1   one-cycle acknowledge
//  wbs_dat_o   out  32  read data, valid with ack
//  irq_o       out  1   done interrupt (present only with FIR_IRQ_EN)
// BEHAVIOUR
//  - One clock domain, wb_clk_i. Reset is synchronous and active-high, on wb_rst_i.
//  - Reset state:
//    - ack=0, dat_o=0, irq_o=0
//    - ap_ctrl = idle(1), done(0), start(0)
//    - length=0, taps=0, history=0
//    - x_full=0, y_valid=0
//  - Decode: the block is selected when cyc & stb & adr[31:24]==BASE_HI. Offset is adr[7:0].
//  - Register map (offsets):
//    - 0x00 ap_ctrl: bit0 start (W1), bit1 done (RO, clear-on-read), bit2 idle (RO)
//    - 0x10 data_length
//    - 0x40..0x68 tap[0..10], one word each
//    - 0x80 X (write only)
//    - 0x84 Y (read only)
//    - Unmapped offsets: ack, read 0, writes ignored.
//  - Register accesses ack one cycle after select. Ack lasts exactly one cycle.
//  - Writes to taps or length while not idle are acked and ignored.
//  - Start: writing start=1 while idle takes effect next cycle.
//    - idle<=0, start pulses high for 1 cycle.
//    - History and sample counter are cleared.
//    - Start written while busy is ignored.
//  - X write:
//    - Acked when the input slot is empty.
//    - Otherwise ack is withheld (the bus stalls) until the MAC has taken the slot.
//    - An X write while idle is acked and dropped.
//  - MAC:
//    - Shifts X into history[0].
//    - Accumulates sum(tap[i]*history[i]), one product per cycle, NUM_TAPS cycles.
//    - History entries not yet written count as 0.
//    - Signed DATA_W arithmetic; wrap on overflow, no saturation.
//    - The result is latched in Y, then y_valid<=1.
//    - Latency: 11+1 cycles from X acceptance to y_valid.
//  - Y read: ack is held off until y_valid. On ack, y_valid<=0.
//  - After the data_length-th Y is read: done<=1, idle<=1.
//  - Reading ap_ctrl returns the current bits, then clears done.
//  - data_length=0: start sets done and idle on the next cycle.
//  - wb_rst_i mid-run aborts the computation and returns to the reset state.
// CONFIGURATION
//  FIR_IRQ_EN defined:
//    - irq_o goes to 1 when done sets.
//    - irq_o stays 1 until ap_ctrl is read.
//  FIR_IRQ_EN undefined:
//    - irq_o port is absent.
//    - No interrupt logic.
// STRUCTURE
//  Package caravel_fir_pkg holds:
//    - register offsets
//    - ap_ctrl bit indices
//    - NUM_TAPS and DATA_W
//    - MAC FSM state enum: IDLE, WAIT_X, MAC, OUT
//  Sub-module fir_mac_core holds the tap and history registers and the MAC FSM.
//  The top level handles Wishbone decode, ack/stall and ap_ctrl.
// TESTING
//  - Reset, then read 0x00 -> 0x4. Read tap[3] -> 0.
//  - Taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, length 64, start, X=0..63:
//    - Y[0..5] = 0, 0, -10, -29, -25, 35
//    - Y[n] = 183n-915 for n>=10 (Y[10]=915, Y[63]=10614)
//  - After the 64th Y read: ap_ctrl = 0x6. A second read = 0x4.
//  - Three back-to-back runs with identical data give identical Y sequences (history clears on start).
//  - Write X twice without reading Y:
//    - The second ack is stalled until the MAC takes the first X.
//    - Reading Y before it is computed is stalled until y_valid.
//  - Assert wb_rst_i mid-run -> idle=1 and taps=0 next cycle. With FIR_IRQ_EN, irq_o=0.

Source files
------------

// File: rtl/caravel_fir_pkg.sv
// Package: caravel_fir_pkg
// Shared constants for the Caravel user-area FIR accelerator: register map,
// ap_ctrl bit positions, datapath sizes, the MAC FSM state type and a
// byte-lane merge helper used for register writes.
// Optional feature macro used by the top level: FIR_IRQ_EN.
package caravel_fir_pkg;

  localparam int NUM_TAPS  = 11;
  localparam int DATA_W    = 32;
  localparam int TAP_IDX_W = 4;

  localparam logic [TAP_IDX_W-1:0] LAST_TAP = TAP_IDX_W'(NUM_TAPS - 1);

  localparam logic [7:0] OFS_AP_CTRL  = 8'h00;
  localparam logic [7:0] OFS_LENGTH   = 8'h10;
  localparam logic [7:0] OFS_TAP_BASE = 8'h40;
  localparam logic [7:0] OFS_X        = 8'h80;
  localparam logic [7:0] OFS_Y        = 8'h84;

  localparam int AP_START = 0;
  localparam int AP_DONE  = 1;
  localparam int AP_IDLE  = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_X,
    MAC,
    OUT
  } mac_state_e;

  // Replace only the byte lanes enabled in sel, keep the rest of old_val.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [3:0]        sel
  );
    logic [DATA_W-1:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/caravel_user_fir_mac_core.sv
// Module: fir_mac_core
// Holds the coefficient and sample-history registers, the single input slot,
// the output register and the MAC FSM. One product is accumulated per cycle.
module fir_mac_core
  import caravel_fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  input  logic                 x_push,
  input  logic [DATA_W-1:0]    x_data,
  input  logic                 y_pop,
  input  logic                 tap_we,
  input  logic [TAP_IDX_W-1:0] tap_idx,
  input  logic [DATA_W-1:0]    tap_wdata,
  output logic [DATA_W-1:0]    tap_rdata,
  output logic                 x_full,
  output logic [DATA_W-1:0]    y_data,
  output logic                 y_valid
);

  mac_state_e           state_q, state_d;
  logic [DATA_W-1:0]    tap_q  [NUM_TAPS];
  logic [DATA_W-1:0]    tap_d  [NUM_TAPS];
  logic [DATA_W-1:0]    hist_q [NUM_TAPS];
  logic [DATA_W-1:0]    hist_d [NUM_TAPS];
  logic [TAP_IDX_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]    x_q, x_d;
  logic                 x_full_q, x_full_d;
  logic [DATA_W-1:0]    y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic [DATA_W-1:0]    acc_next;

  assign tap_rdata = (tap_idx <= LAST_TAP) ? tap_q[tap_idx] : '0;
  assign x_full    = x_full_q;
  assign y_data    = y_q;
  assign y_valid   = y_valid_q;

  // Keeping only the low DATA_W bits of the product and sum gives signed
  // wrap-around arithmetic regardless of operand signedness.
  assign acc_next = acc_q + tap_q[idx_q] * hist_q[idx_q];

  // Next-state logic: FSM, slot handshakes, then start/finish overrides.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    hist_d    = hist_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    x_d       = x_q;
    x_full_d  = x_full_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;

    if (tap_we && (tap_idx <= LAST_TAP)) begin
      tap_d[tap_idx] = tap_wdata;
    end

    case (state_q)
      IDLE: begin
      end
      WAIT_X: begin
        if (x_full_q) begin
          for (int i = NUM_TAPS - 1; i > 0; i--) begin
            hist_d[i] = hist_q[i-1];
          end
          hist_d[0] = x_q;
          x_full_d  = 1'b0;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        if (idx_q == LAST_TAP) begin
          y_d       = acc_next;
          y_valid_d = 1'b1;
          state_d   = OUT;
        end else begin
          acc_d = acc_next;
          idx_d = idx_q + 1'b1;
        end
      end
      OUT: begin
        // Hold the next sample back until Y has been read, so no result is lost.
        if (!y_valid_q) begin
          state_d = WAIT_X;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist_d[i] = '0;
      end
      x_full_d  = 1'b0;
      y_valid_d = 1'b0;
      state_d   = WAIT_X;
    end

    if (x_push) begin
      x_d      = x_data;
      x_full_d = 1'b1;
    end

    if (y_pop) begin
      y_valid_d = 1'b0;
    end

    if (finish) begin
      x_full_d  = 1'b0;
      y_valid_d = 1'b0;
      state_d   = IDLE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      x_full_q  <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        tap_q[i]  <= '0;
        hist_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      x_full_q  <= x_full_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      tap_q     <= tap_d;
      hist_q    <= hist_d;
    end
  end

endmodule

// File: rtl/caravel_user_fir.sv
// Module: caravel_user_fir
// Wishbone slave front end for the 11-tap FIR: address decode, ack/stall
// generation, ap_ctrl handshake and output sample counting.
// Optional feature macro: FIR_IRQ_EN (adds irq_o, a sticky done interrupt).
module caravel_user_fir
  import caravel_fir_pkg::*;
#(
  parameter logic [7:0] BASE_HI = 8'h30
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
`ifdef FIR_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 idle_q, idle_d;
  logic [DATA_W-1:0]    length_q, length_d;
  logic [DATA_W-1:0]    ycnt_q, ycnt_d;
`ifdef FIR_IRQ_EN
  logic                 irq_q, irq_d;
`endif

  logic                 bus_sel;
  logic [7:0]           ofs;
  logic [TAP_IDX_W-1:0] tap_idx;
  logic                 is_tap;
  logic                 set_done;
  logic                 finish;
  logic                 x_push;
  logic                 y_pop;
  logic                 tap_we;
  logic [DATA_W-1:0]    tap_wdata;
  logic [DATA_W-1:0]    tap_rdata;
  logic                 x_full;
  logic [DATA_W-1:0]    y_data;
  logic                 y_valid;
  logic                 unused_adr;

  assign bus_sel    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
  assign ofs        = wbs_adr_i[7:0];
  assign tap_idx    = ofs[5:2];
  assign is_tap     = (ofs[7:6] == OFS_TAP_BASE[7:6]) && (ofs[1:0] == 2'b00) &&
                      (tap_idx <= LAST_TAP);
  assign tap_wdata  = merge_bytes(tap_rdata, wbs_dat_i, wbs_sel_i);
  assign unused_adr = ^wbs_adr_i[23:8];

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
`ifdef FIR_IRQ_EN
  assign irq_o = irq_q;
`endif

  fir_mac_core u_core (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .start     (start_q),
    .finish    (finish),
    .x_push    (x_push),
    .x_data    (wbs_dat_i),
    .y_pop     (y_pop),
    .tap_we    (tap_we),
    .tap_idx   (tap_idx),
    .tap_wdata (tap_wdata),
    .tap_rdata (tap_rdata),
    .x_full    (x_full),
    .y_data    (y_data),
    .y_valid   (y_valid)
  );

  // Bus decode: one ack per transfer, X/Y stall on slot state, ap_ctrl updates.
  always_comb begin
    ack_d    = 1'b0;
    dat_d    = '0;
    start_d  = 1'b0;
    done_d   = done_q;
    idle_d   = idle_q;
    length_d = length_q;
    ycnt_d   = ycnt_q;
    x_push   = 1'b0;
    y_pop    = 1'b0;
    tap_we   = 1'b0;
    finish   = 1'b0;
    set_done = 1'b0;
`ifdef FIR_IRQ_EN
    irq_d    = irq_q;
`endif

    if (bus_sel && !ack_q) begin
      if (wbs_we_i) begin
        case (ofs)
          OFS_AP_CTRL: begin
            ack_d = 1'b1;
            if (wbs_sel_i[0] && wbs_dat_i[AP_START] && idle_q) begin
              start_d = 1'b1;
              idle_d  = 1'b0;
              ycnt_d  = '0;
            end
          end
          OFS_LENGTH: begin
            ack_d = 1'b1;
            if (idle_q) length_d = merge_bytes(length_q, wbs_dat_i, wbs_sel_i);
          end
          OFS_X: begin
            if (idle_q) begin
              ack_d = 1'b1;
            end else if (!x_full) begin
              ack_d  = 1'b1;
              x_push = 1'b1;
            end
          end
          default: begin
            ack_d = 1'b1;
            if (is_tap && idle_q) tap_we = 1'b1;
          end
        endcase
      end else begin
        case (ofs)
          OFS_AP_CTRL: begin
            ack_d           = 1'b1;
            dat_d[AP_START] = start_q;
            dat_d[AP_DONE]  = done_q;
            dat_d[AP_IDLE]  = idle_q;
            done_d          = 1'b0;
`ifdef FIR_IRQ_EN
            irq_d           = 1'b0;
`endif
          end
          OFS_LENGTH: begin
            ack_d = 1'b1;
            dat_d = length_q;
          end
          OFS_Y: begin
            // While idle no Y will ever arrive, so answer 0 rather than hang the bus.
            if (y_valid) begin
              ack_d  = 1'b1;
              dat_d  = y_data;
              y_pop  = 1'b1;
              ycnt_d = ycnt_q + 32'd1;
              if (ycnt_d == length_q) set_done = 1'b1;
            end else if (idle_q) begin
              ack_d = 1'b1;
            end
          end
          default: begin
            ack_d = 1'b1;
            if (is_tap) dat_d = tap_rdata;
          end
        endcase
      end
    end

    if (start_q && (length_q == '0)) set_done = 1'b1;

    if (set_done) begin
      done_d = 1'b1;
      idle_d = 1'b1;
      finish = 1'b1;
`ifdef FIR_IRQ_EN
      irq_d  = 1'b1;
`endif
    end
  end

  // Bus and control registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
      length_q <= '0;
      ycnt_q   <= '0;
`ifdef FIR_IRQ_EN
      irq_q    <= 1'b0;
`endif
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      start_q  <= start_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
      length_q <= length_d;
      ycnt_q   <= ycnt_d;
`ifdef FIR_IRQ_EN
      irq_q    <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_caravel_user_fir.sv
// Testbench: tb_caravel_user_fir
// Directed Wishbone sequence against caravel_user_fir with a reference FIR
// model feeding an expected-Y queue. Honours FIR_IRQ_EN for the irq_o checks.
`timescale 1ns/1ps
module tb_caravel_user_fir;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_LEN  = BASE + 32'h10;
  localparam logic [31:0] A_TAP0 = BASE + 32'h40;
  localparam logic [31:0] A_TAP3 = BASE + 32'h4C;
  localparam logic [31:0] A_X    = BASE + 32'h80;
  localparam logic [31:0] A_Y    = BASE + 32'h84;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
`ifdef FIR_IRQ_EN
  logic        irq_o;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] tap_tbl [11];
  logic [31:0] hist_m [11];

  caravel_user_fir dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o)
`ifdef FIR_IRQ_EN
    ,
    .irq_o     (irq_o)
`endif
  );

  // 100 MHz clock.
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Hard stop in case a bus wait is ever mis-bounded.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One Wishbone transfer, driven on the falling edge and sampled 1ns after rising edges.
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input int budget,
                           output logic [31:0] rdat, output logic acked, output int waited);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = wdat;
    wbs_sel_i = sel;
    acked  = 1'b0;
    waited = 0;
    rdat   = '0;
    while (!acked && (waited < budget)) begin
      @(posedge wb_clk_i);
      #1;
      waited++;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wbWrite(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel = 4'hF);
    logic [31:0] unused_rd;
    logic        acked;
    int          waited;
    wb_access(1'b1, adr, dat, sel, 100, unused_rd, acked, waited);
    checkOutput($sformatf("write_ack_%02h", adr[7:0]), {31'd0, acked}, 32'd1);
  endtask

  task automatic wbRead(input logic [31:0] adr, output logic [31:0] dat, output int waited);
    logic acked;
    wb_access(1'b0, adr, 32'd0, 4'hF, 100, dat, acked, waited);
    checkOutput($sformatf("read_ack_%02h", adr[7:0]), {31'd0, acked}, 32'd1);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] adr, input logic [31:0] expected);
    logic [31:0] dat;
    int          waited;
    wbRead(adr, dat, waited);
    checkOutput(tag, dat, expected);
  endtask

  // Start a run: the model history clears with the DUT's.
  task automatic doStart();
    for (int i = 0; i < 11; i++) hist_m[i] = '0;
    wbWrite(A_CTRL, 32'd1);
  endtask

  // Drive one X sample and queue the Y the reference FIR predicts for it.
  task automatic applyStimulus(input logic [31:0] x);
    logic [31:0] acc;
    for (int i = 10; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = x;
    acc = '0;
    for (int i = 0; i < 11; i++) acc = acc + tap_tbl[i] * hist_m[i];
    exp_q.push_back(acc);
    wbWrite(A_X, x);
  endtask

  // Read one Y and compare it with the oldest queued prediction.
  task automatic readY(output logic [31:0] y, output int waited);
    wbRead(A_Y, y, waited);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL y_underflow: observed=%h expected=none", y);
    end else begin
      checkOutput("y_sample", y, exp_q.pop_front());
    end
  endtask

  initial begin
    int          spec_y [6];
    int          tap_vals [11];
    logic [31:0] y;
    logic [31:0] rd;
    logic        acked;
    int          waited;

    spec_y   = '{0, 0, -10, -29, -25, 35};
    tap_vals = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < 11; i++) begin
      tap_tbl[i] = 32'(tap_vals[i]);
      hist_m[i]  = '0;
    end

    wb_rst_i  = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    checkOutput("rst_dat", wbs_dat_o, 32'd0);
`ifdef FIR_IRQ_EN
    checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
`endif
    readCheck("rst_ap_ctrl", A_CTRL, 32'h4);
    readCheck("rst_tap3", A_TAP3, 32'd0);
    readCheck("rst_length", A_LEN, 32'd0);

    $display("[TB] program taps and length");
    for (int i = 0; i < 11; i++) wbWrite(A_TAP0 + 32'(4 * i), tap_tbl[i]);
    wbWrite(A_LEN, 32'd64);
    readCheck("tap3_readback", A_TAP3, 32'd23);

    for (int run = 0; run < 3; run++) begin
      $display("[TB] run %0d", run);
      doStart();
      if (run == 0) readCheck("ap_ctrl_busy", A_CTRL, 32'h0);
      for (int n = 0; n < 64; n++) begin
        applyStimulus(32'(n));
        if (run == 0 && n == 20) wbWrite(A_TAP3, 32'd99);
        if (run == 1 && n == 30) wbWrite(A_CTRL, 32'd1);
        readY(y, waited);
        if (run == 0 && n < 6) checkOutput($sformatf("spec_y%0d", n), y, 32'(spec_y[n]));
        if (run == 0 && (n == 10 || n == 63)) checkOutput($sformatf("spec_y%0d", n), y, 32'(183 * n - 915));
      end
`ifdef FIR_IRQ_EN
      checkOutput("irq_done", {31'd0, irq_o}, 32'd1);
`endif
      readCheck("ap_ctrl_done", A_CTRL, 32'h6);
      readCheck("ap_ctrl_clr", A_CTRL, 32'h4);
`ifdef FIR_IRQ_EN
      checkOutput("irq_clr", {31'd0, irq_o}, 32'd0);
`endif
    end
    readCheck("tap3_busy_write_ignored", A_TAP3, 32'd23);

    $display("[TB] X slot stall");
    wbWrite(A_LEN, 32'd2);
    doStart();
    applyStimulus(32'd5);
    applyStimulus(32'd7);
    wb_access(1'b1, A_X, 32'd9, 4'hF, 20, rd, acked, waited);
    checkOutput("x_stall", {31'd0, acked}, 32'd0);
    readY(y, waited);
    readY(y, waited);
    readCheck("stall_done", A_CTRL, 32'h6);
    readCheck("stall_clr", A_CTRL, 32'h4);

    $display("[TB] Y read stall");
    wbWrite(A_LEN, 32'd1);
    doStart();
    applyStimulus(32'd3);
    readY(y, waited);
    checkOutput("y_stall", {31'd0, waited >= 12}, 32'd1);
    readCheck("ystall_done", A_CTRL, 32'h6);

    $display("[TB] byte enables and unmapped space");
    wbWrite(A_LEN, 32'h1234_5678);
    wbWrite(A_LEN, 32'hAAAA_AAAA, 4'b0010);
    readCheck("length_sel", A_LEN, 32'h1234_AA78);
    wbWrite(BASE + 32'h20, 32'hFFFF_FFFF);
    readCheck("unmapped_read", BASE + 32'h20, 32'd0);
    readCheck("x_read", A_X, 32'd0);
    wb_access(1'b0, 32'h3100_0000, 32'd0, 4'hF, 5, rd, acked, waited);
    checkOutput("foreign_addr", {31'd0, acked}, 32'd0);

    $display("[TB] zero length");
    wbWrite(A_LEN, 32'd0);
    doStart();
    readCheck("len0_done", A_CTRL, 32'h6);
    readCheck("len0_clr", A_CTRL, 32'h4);

    $display("[TB] reset mid-run");
    wbWrite(A_LEN, 32'd64);
    doStart();
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    exp_q.delete();
    checkOutput("midrst_ack", {31'd0, wbs_ack_o}, 32'd0);
`ifdef FIR_IRQ_EN
    checkOutput("midrst_irq", {31'd0, irq_o}, 32'd0);
`endif
    readCheck("midrst_ap_ctrl", A_CTRL, 32'h4);
    readCheck("midrst_tap3", A_TAP3, 32'd0);
    readCheck("midrst_length", A_LEN, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
